// File: rtl/retimer_pol_ctrl.sv
// rtl/retimer_pol_ctrl.sv - closed-loop polarity select for the FOD pos/neg output retimer
// Classifies divider-edge phase, debounces switch decisions and commits them only while D is low.
module retimer_pol_ctrl #(
  parameter int PW       = 10,
  parameter int WIN      = 128,
  parameter int PERSIST  = 4,
  parameter int HOLDOFF  = 16,
  parameter int LOCK_N   = 8,
  parameter int SWW      = 8,
  parameter bit POL_INIT = 1'b0
) (
  input  logic           CK,
  input  logic           RSTN,
  input  logic           CAL_EN,
  input  logic           POL_MAN,
  input  logic [PW-1:0]  PHASE,
  input  logic           PH_VLD,
  input  logic           D_LO,
  output logic           POLARITY,
  output logic           LOCKED,
  output logic [SWW-1:0] SW_CNT,
  output logic           BUSY
);

  localparam int PMAX = (2 ** PW) - 1;
  localparam int HALF = 2 ** (PW - 1);
  localparam int DW   = $clog2(PERSIST + 1);
  localparam int AW   = $clog2(LOCK_N + 1);
  localparam int HW   = $clog2(HOLDOFF + 1);

  localparam logic [DW-1:0] DIS_LAST  = DW'(PERSIST - 1);
  localparam logic [AW-1:0] AGR_FULL  = AW'(LOCK_N);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TRACK  = 3'd1,
    PEND   = 3'd2,
    COMMIT = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] dis_cnt;
  logic [AW-1:0] agr_cnt;
  logic [HW-1:0] hold_cnt;
  logic          pend_cal;
  logic          smp_vld, smp_neg, smp_pos;

  logic [31:0] ph_w;
  logic        want_neg_c, want_pos_c;
  logic        smp_cls, disagree, agree;

  // Edge near CK rise wants the negedge-retimed path (1); near CK fall the direct path (0).
  assign ph_w       = 32'(PHASE);
  assign want_neg_c = (ph_w < 32'(WIN)) || (ph_w > 32'(PMAX - WIN));
  assign want_pos_c = (ph_w > 32'(HALF - WIN)) && (ph_w < 32'(HALF + WIN));

  assign smp_cls  = smp_neg | smp_pos;
  assign disagree = smp_vld && smp_cls && (smp_neg != POLARITY);
  assign agree    = smp_vld && smp_cls && (smp_neg == POLARITY);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (CAL_EN)                    state_nxt = TRACK;
        else if (POL_MAN != POLARITY)  state_nxt = PEND;
      end
      TRACK: begin
        if (!CAL_EN)                              state_nxt = IDLE;
        else if (disagree && dis_cnt == DIS_LAST) state_nxt = PEND;
      end
      PEND: begin
        // A mode change aborts the pending switch; manual mode re-evaluates from IDLE.
        if (CAL_EN != pend_cal)                     state_nxt = CAL_EN ? TRACK : IDLE;
        else if (!pend_cal && POL_MAN == POLARITY)  state_nxt = IDLE;
        else if (D_LO)                              state_nxt = COMMIT;
      end
      COMMIT: state_nxt = HOLD;
      HOLD: begin
        if (hold_cnt == HOLD_LAST) state_nxt = CAL_EN ? TRACK : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= IDLE;
      POLARITY <= POL_INIT;
      SW_CNT   <= '0;
      dis_cnt  <= '0;
      agr_cnt  <= '0;
      hold_cnt <= '0;
      pend_cal <= 1'b0;
      smp_vld  <= 1'b0;
      smp_neg  <= 1'b0;
      smp_pos  <= 1'b0;
    end else begin
      state <= state_nxt;

      // Strobes landing in holdoff or on the commit transition never reach the tracker.
      smp_vld <= PH_VLD && (state != HOLD) && (state_nxt != COMMIT);
      if (PH_VLD) begin
        smp_neg <= want_neg_c;
        smp_pos <= want_pos_c;
      end

      if (state != PEND && state_nxt == PEND) pend_cal <= (state == TRACK);

      if (state == TRACK) begin
        if (disagree) begin
          dis_cnt <= dis_cnt + 1'b1;
          agr_cnt <= '0;
        end else if (agree) begin
          dis_cnt <= '0;
          if (agr_cnt != AGR_FULL) agr_cnt <= agr_cnt + 1'b1;
        end
      end else begin
        dis_cnt <= '0;
        agr_cnt <= '0;
      end

      if (state == COMMIT) begin
        POLARITY <= ~POLARITY;
        if (SW_CNT != {SWW{1'b1}}) SW_CNT <= SW_CNT + 1'b1;
      end

      hold_cnt <= (state == HOLD) ? hold_cnt + 1'b1 : '0;
    end
  end

  assign BUSY   = (state == PEND) || (state == HOLD);
  assign LOCKED = (state == TRACK) && (agr_cnt == AGR_FULL);

endmodule

// File: doc/retimer_pol_ctrl.md
Name: retimer_pol_ctrl

Overview:
- Closed-loop controller that drives the POLARITY select of the FOD output pos/neg retimer.
- Classifies the divider-edge phase each time a fresh phase word arrives, then decides which CK edge samples safely: POLARITY=0 selects the direct path, POLARITY=1 the negedge-retimed path.
- Debounces each switch decision, applies switches only while the divider output is low (glitch-free), and reports lock and switch statistics.
- Sits between the DTC/phase accumulator and the retimer.

Parameters:
- PW, 10, phase word width; PHASE is a fraction of one CK period, 0..2^PW-1.
- WIN, 128, half-width of each keep-out window, in phase LSBs.
- PERSIST, 4, consecutive disagreeing valid samples required before a switch.
- HOLDOFF, 16, CK cycles after a switch during which samples are ignored.
- LOCK_N, 8, consecutive agreeing valid samples required to assert LOCKED.
- SWW, 8, width of the switch counter.
- POL_INIT, 0, POLARITY value at reset.

Ports:
- CK, input, 1, controller clock (same CK as the retimer).
- RSTN, input, 1, asynchronous active-low reset.
- CAL_EN, input, 1, 1 = automatic tracking; 0 = manual mode.
- POL_MAN, input, 1, polarity requested in manual mode.
- PHASE, input, PW, divider-edge phase relative to CK rising edge.
- PH_VLD, input, 1, one-cycle strobe qualifying PHASE.
- D_LO, input, 1, high while the divider output D is low (already synchronised to CK).
- POLARITY, output, 1, retimer select.
- LOCKED, output, 1, tracking stable.
- SW_CNT, output, SWW, number of polarity changes, saturating.
- BUSY, output, 1, a switch is pending or in holdoff.

Behaviour:
- Reset (RSTN=0, async): POLARITY=POL_INIT, LOCKED=0, SW_CNT=0, BUSY=0, state=IDLE, all internal counters 0. Reset mid-switch aborts the switch; POLARITY still returns to POL_INIT.
- Phase classification, registered on PH_VLD:
  - WANT_NEG when PHASE < WIN or PHASE > 2^PW-1-WIN (edge near CK rise).
  - WANT_POS when |PHASE - 2^(PW-1)| < WIN (edge near CK fall).
  - Otherwise NEUTRAL.
  - Samples are used one cycle after PH_VLD.
- State IDLE (CAL_EN=0):
  - If POL_MAN != POLARITY, go to PEND with target POL_MAN.
  - LOCKED=0.
  - CAL_EN=1 moves to TRACK with counters cleared.
- State TRACK, on each valid sample:
  - Wanted polarity != POLARITY: dis_cnt++ and agr_cnt=0.
  - Wanted polarity == POLARITY: agr_cnt++ (saturates at LOCK_N) and dis_cnt=0.
  - NEUTRAL: both counters hold.
  - When dis_cnt reaches PERSIST, go to PEND with target=!POLARITY.
  - LOCKED=1 when agr_cnt==LOCK_N and state==TRACK, otherwise 0.
  - No PH_VLD: no change.
- State PEND:
  - BUSY=1, LOCKED=0.
  - Waits for D_LO=1. In the cycle D_LO is seen high, go to COMMIT.
  - A CAL_EN change while in PEND returns to IDLE/TRACK per CAL_EN without switching; in manual mode it re-evaluates POL_MAN.
- State COMMIT (one cycle):
  - POLARITY<=target.
  - SW_CNT<=SW_CNT+1, saturating at 2^SWW-1.
  - dis_cnt=agr_cnt=0; then HOLD.
- State HOLD:
  - BUSY=1; PH_VLD is ignored.
  - Counts HOLDOFF cycles, then returns to TRACK if CAL_EN=1, else IDLE.
- POLARITY never changes outside COMMIT, so it is stable whenever D_LO=0.
- Simultaneous events:
  - PH_VLD in the same cycle as the PEND→COMMIT transition is dropped.
  - CAL_EN falling in COMMIT still completes the switch.
- Latency: best case, PERSIST-th disagreeing PH_VLD at cycle t → POLARITY changes at t+3 (sample register, PEND with D_LO=1, COMMIT).

Test Plan:
- Reset: POL_INIT=0, hold RSTN=0 → POLARITY=0, SW_CNT=0, LOCKED=0, BUSY=0; assert RSTN=0 asynchronously during PEND → outputs return to reset values immediately.
- Lock: CAL_EN=1, D_LO=1, 8 strobes with PHASE=512 → no switch, LOCKED=1 after the 8th sample, SW_CNT=0.
- Debounce and switch:
  - PHASE=10 on 3 strobes then PHASE=512 → no switch.
  - Then 4 strobes with PHASE=1000 → POLARITY=1 three cycles after the 4th, SW_CNT=1, BUSY high for 1+16 cycles.
- D_LO gating: trigger a switch with D_LO=0 held for 20 cycles → POLARITY unchanged and BUSY=1; D_LO rises → POLARITY toggles the next cycle.
- Hysteresis and holdoff:
  - PHASE=300 (NEUTRAL) on repeated strobes → counters hold, no switch.
  - Strobes during HOLD → ignored.
- Manual and saturation:
  - CAL_EN=0, toggle POL_MAN 300 times with D_LO=1 → POLARITY follows each toggle.
  - SW_CNT saturates at 255.
